pipe_stall_ctrl: RTL and testbench

- Central pipeline stall controller for the 5-stage MIPS32 core. It generates the 4-bit `stall` vector consumed by the PC, IF/ID, ID/EXE and EXE/MEM pipeline registers.
- It sequences the multi-cycle divider that sits in the EXE stage: it detects DIV/DIVU in EXE, freezes the pipe, starts the divider, waits for its result and then releases the pipe.
- It merges the decode-stage load-use stall request with the divider stall and keeps a saturating stall-cycle performance counter.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/pipe_stall_ctrl_if.sv | 27 ++
 rtl/pipe_stall_ctrl_sat_counter.sv | 19 +
 rtl/pipe_stall_ctrl.sv | 93 +++++++++
 tb/tb_pipe_stall_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 core constants: opcodes the stall controller decodes, stall vectors
// and the divider-sequencer state encoding.
package mips_pkg;

  localparam logic [7:0] OP_DIV        = 8'h1A;
  localparam logic [7:0] OP_DIVU       = 8'h1B;
  localparam logic [7:0] OP_NOP_BUBBLE = 8'h16;

  // Bit order: [0]=PC, [1]=IF/ID, [2]=ID/EXE, [3]=EXE/MEM hold
  localparam logic [3:0] STALL_NONE    = 4'b0000;
  localparam logic [3:0] STALL_LOADUSE = 4'b0111;
  localparam logic [3:0] STALL_ALL     = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } div_state_t;

  function automatic logic is_div(input logic [7:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Signal bundle between the pipeline/divider and the stall controller.
// The pipeline side (master) drives requests; the controller (slave) drives stalls and divider control.
interface pipe_stall_ctrl_if #(parameter int CNT_W = 32);
  import mips_pkg::*;

  logic             stallreq_id;
  logic [7:0]       exe_aluop;
  logic             div_ready;
  logic [3:0]       stall;
  logic             div_start;
  logic             div_signed;
  logic             div_done;
  logic             div_err;
  logic [CNT_W-1:0] stall_cnt;
  div_state_t       state;

  modport master (
    output stallreq_id, exe_aluop, div_ready,
    input  stall, div_start, div_signed, div_done, div_err, stall_cnt, state
  );

  modport slave (
    input  stallreq_id, exe_aluop, div_ready,
    output stall, div_start, div_signed, div_done, div_err, stall_cnt, state
  );

endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller: sequences the EXE-stage divider (IDLE->START->BUSY->DONE),
// merges the decode load-use request and counts stalled cycles.
module pipe_stall_ctrl
  import mips_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 32
) (
  input  logic clk,
  input  logic rst_n,
  pipe_stall_ctrl_if.slave bus
);

  localparam int            TO_W    = $clog2(DIV_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DIV_TIMEOUT - 1);

  div_state_t      state_q, state_next;
  logic [TO_W-1:0] to_cnt;
  logic            div_signed_q;
  logic            div_err_q;
  logic            div_in_exe;
  logic            timeout_hit;

  assign div_in_exe  = is_div(bus.exe_aluop);
  assign timeout_hit = (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      to_cnt       <= '0;
      div_signed_q <= 1'b0;
      div_err_q    <= 1'b0;
    end else begin
      state_q <= state_next;
      if (state_q == ST_IDLE && div_in_exe) begin
        div_signed_q <= (bus.exe_aluop == OP_DIV);
      end
      if (state_q == ST_START) begin
        to_cnt <= '0;
      end else if (state_q == ST_BUSY) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      // A result arriving on the last allowed cycle still counts as a clean finish
      if (state_q == ST_BUSY && !bus.div_ready && timeout_hit) begin
        div_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state_q;
    bus.div_start = 1'b0;
    bus.div_done  = 1'b0;
    case (state_q)
      ST_IDLE:  if (div_in_exe) state_next = ST_START;
      ST_START: begin
        bus.div_start = 1'b1;
        state_next    = ST_BUSY;
      end
      ST_BUSY:  if (bus.div_ready || timeout_hit) state_next = ST_DONE;
      ST_DONE:  begin
        bus.div_done = 1'b1;
        state_next   = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // Held in reset the stall vector reads zero even if a divide sits in EXE
  always_comb begin
    bus.stall = STALL_NONE;
    if (!rst_n) begin
      bus.stall = STALL_NONE;
    end else if ((state_q == ST_IDLE && div_in_exe) ||
                 state_q == ST_START || state_q == ST_BUSY) begin
      bus.stall = STALL_ALL;
    end else if (bus.stallreq_id) begin
      bus.stall = STALL_LOADUSE;
    end
  end

  assign bus.div_signed = div_signed_q;
  assign bus.div_err    = div_err_q;
  assign bus.state      = state_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.stall != STALL_NONE),
    .count (bus.stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: inputs change on the falling edge, outputs checked 1ns later.
module tb_pipe_stall_ctrl;
  import mips_pkg::*;

  localparam int DIV_TIMEOUT = 40;
  localparam int CNT_W       = 32;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_stall_ctrl #(.DIV_TIMEOUT(DIV_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic req, input logic [7:0] op, input logic rdy);
    bus.stallreq_id = req;
    bus.exe_aluop   = op;
    bus.div_ready   = rdy;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    total_cnt++; if (bus.stall !== 4'b0000) $display("FAIL rst_stall got %b exp 0000", bus.stall); else pass_cnt++;
    total_cnt++; if (bus.div_start !== 1'b0 || bus.div_done !== 1'b0 || bus.div_signed !== 1'b0 || bus.div_err !== 1'b0)
      $display("FAIL rst_div got start=%b done=%b sgn=%b err=%b exp all 0", bus.div_start, bus.div_done, bus.div_signed, bus.div_err);
    else pass_cnt++;
    total_cnt++; if (bus.stall_cnt !== 32'd0) $display("FAIL rst_cnt got %0d exp 0", bus.stall_cnt); else pass_cnt++;
    total_cnt++; if (bus.state !== ST_IDLE) $display("FAIL rst_state got %0d exp 0", bus.state); else pass_cnt++;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      total_cnt++; if (bus.stall !== 4'b0000) $display("FAIL idle_stall[%0d] got %b exp 0000", i, bus.stall); else pass_cnt++;
      tick();
    end
    total_cnt++; if (bus.stall_cnt !== 32'd0) $display("FAIL idle_cnt got %0d exp 0", bus.stall_cnt); else pass_cnt++;
    total_cnt++; if (bus.div_err !== 1'b0) $display("FAIL idle_err got %b exp 0", bus.div_err); else pass_cnt++;
  endtask

  task automatic test_load_use();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'h00, 1'b0);
      total_cnt++; if (bus.stall !== 4'b0111) $display("FAIL lu_stall[%0d] got %b exp 0111", i, bus.stall); else pass_cnt++;
      tick();
    end
    drive(1'b0, 8'h00, 1'b0);
    total_cnt++; if (bus.stall !== 4'b0000) $display("FAIL lu_release got %b exp 0000", bus.stall); else pass_cnt++;
    total_cnt++; if (bus.stall_cnt !== 32'd2) $display("FAIL lu_cnt got %0d exp 2", bus.stall_cnt); else pass_cnt++;
  endtask

  task automatic test_div();
    do_reset();
    // cycle 0: IDLE sees DIV
    drive(1'b0, OP_DIV, 1'b0);
    total_cnt++; if (bus.stall !== 4'b1111) $display("FAIL div_c0_stall got %b exp 1111", bus.stall); else pass_cnt++;
    total_cnt++; if (bus.div_start !== 1'b0) $display("FAIL div_c0_start got %b exp 0", bus.div_start); else pass_cnt++;
    tick();
    // cycle 1: START
    total_cnt++; if (bus.div_start !== 1'b1) $display("FAIL div_c1_start got %b exp 1", bus.div_start); else pass_cnt++;
    total_cnt++; if (bus.div_signed !== 1'b1) $display("FAIL div_c1_signed got %b exp 1", bus.div_signed); else pass_cnt++;
    total_cnt++; if (bus.stall !== 4'b1111) $display("FAIL div_c1_stall got %b exp 1111", bus.stall); else pass_cnt++;
    tick();
    // cycles 2..4: BUSY, result on cycle 4
    for (int c = 2; c <= 4; c++) begin
      drive(1'b0, OP_DIV, (c == 4));
      total_cnt++; if (bus.stall !== 4'b1111 || bus.div_start !== 1'b0 || bus.div_done !== 1'b0)
        $display("FAIL div_busy[%0d] got stall=%b start=%b done=%b exp 1111/0/0", c, bus.stall, bus.div_start, bus.div_done);
      else pass_cnt++;
      tick();
    end
    // cycle 5: DONE, next instruction loaded at the end of it
    drive(1'b0, 8'h00, 1'b0);
    total_cnt++; if (bus.div_done !== 1'b1) $display("FAIL div_c5_done got %b exp 1", bus.div_done); else pass_cnt++;
    total_cnt++; if (bus.stall !== 4'b0000) $display("FAIL div_c5_stall got %b exp 0000", bus.stall); else pass_cnt++;
    tick();
    total_cnt++; if (bus.div_done !== 1'b0) $display("FAIL div_c6_done got %b exp 0", bus.div_done); else pass_cnt++;
    total_cnt++; if (bus.stall_cnt !== 32'd5) $display("FAIL div_cnt got %0d exp 5", bus.stall_cnt); else pass_cnt++;
    total_cnt++; if (bus.div_err !== 1'b0) $display("FAIL div_err got %b exp 0", bus.div_err); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int starts;
    do_reset();
    starts = 0;
    drive(1'b0, OP_DIVU, 1'b0);
    total_cnt++; if (bus.stall !== 4'b1111) $display("FAIL to_c0_stall got %b exp 1111", bus.stall); else pass_cnt++;
    tick();
    total_cnt++; if (bus.div_start !== 1'b1) $display("FAIL to_c1_start got %b exp 1", bus.div_start); else pass_cnt++;
    total_cnt++; if (bus.div_signed !== 1'b0) $display("FAIL to_c1_signed got %b exp 0", bus.div_signed); else pass_cnt++;
    tick();
    // DIVU stays in EXE for the whole BUSY window and must never relaunch
    for (int i = 0; i < DIV_TIMEOUT; i++) begin
      drive(1'b0, (i == DIV_TIMEOUT - 1) ? 8'h00 : OP_DIVU, 1'b0);
      if (bus.div_start === 1'b1) starts++;
      total_cnt++; if (bus.stall !== 4'b1111 || bus.div_done !== 1'b0 || bus.div_err !== 1'b0)
        $display("FAIL to_busy[%0d] got stall=%b done=%b err=%b exp 1111/0/0", i, bus.stall, bus.div_done, bus.div_err);
      else pass_cnt++;
      tick();
    end
    total_cnt++; if (starts !== 0) $display("FAIL to_relaunch got %0d exp 0", starts); else pass_cnt++;
    total_cnt++; if (bus.div_done !== 1'b1) $display("FAIL to_done got %b exp 1", bus.div_done); else pass_cnt++;
    total_cnt++; if (bus.div_err !== 1'b1) $display("FAIL to_err got %b exp 1", bus.div_err); else pass_cnt++;
    total_cnt++; if (bus.stall !== 4'b0000) $display("FAIL to_done_stall got %b exp 0000", bus.stall); else pass_cnt++;
    tick();
    total_cnt++; if (bus.state !== ST_IDLE) $display("FAIL to_idle got %0d exp 0", bus.state); else pass_cnt++;
    total_cnt++; if (bus.div_done !== 1'b0) $display("FAIL to_done2 got %b exp 0", bus.div_done); else pass_cnt++;
    total_cnt++; if (bus.div_err !== 1'b1) $display("FAIL to_err_sticky got %b exp 1", bus.div_err); else pass_cnt++;
    total_cnt++; if (bus.div_signed !== 1'b0) $display("FAIL to_signed got %b exp 0", bus.div_signed); else pass_cnt++;
    total_cnt++; if (bus.stall_cnt !== 32'd42) $display("FAIL to_cnt got %0d exp 42", bus.stall_cnt); else pass_cnt++;
  endtask

  task automatic test_overlap();
    int starts;
    logic [3:0] exp_stall [0:4];
    exp_stall = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0111};
    do_reset();
    starts = 0;
    for (int c = 0; c <= 4; c++) begin
      drive(1'b1, (c == 4) ? 8'h00 : OP_DIV, (c == 3));
      if (bus.div_start === 1'b1) starts++;
      total_cnt++; if (bus.stall !== exp_stall[c]) $display("FAIL ov_stall[%0d] got %b exp %b", c, bus.stall, exp_stall[c]); else pass_cnt++;
      if (c == 4) begin
        total_cnt++; if (bus.div_done !== 1'b1) $display("FAIL ov_done got %b exp 1", bus.div_done); else pass_cnt++;
      end
      tick();
    end
    drive(1'b1, 8'h00, 1'b0);
    total_cnt++; if (starts !== 1) $display("FAIL ov_starts got %0d exp 1", starts); else pass_cnt++;
    total_cnt++; if (bus.stall !== 4'b0111) $display("FAIL ov_idle_stall got %b exp 0111", bus.stall); else pass_cnt++;
    total_cnt++; if (bus.stall_cnt !== 32'd5) $display("FAIL ov_cnt got %0d exp 5", bus.stall_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_busy();
    int dones;
    do_reset();
    drive(1'b0, OP_DIV, 1'b0);
    tick();
    tick();
    tick();
    total_cnt++; if (bus.state !== ST_BUSY) $display("FAIL mr_in_busy got %0d exp 2", bus.state); else pass_cnt++;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    total_cnt++; if (bus.stall !== 4'b0000 || bus.div_start !== 1'b0 || bus.div_done !== 1'b0 || bus.div_signed !== 1'b0)
      $display("FAIL mr_async got stall=%b start=%b done=%b sgn=%b exp all 0", bus.stall, bus.div_start, bus.div_done, bus.div_signed);
    else pass_cnt++;
    total_cnt++; if (bus.stall_cnt !== 32'd0) $display("FAIL mr_cnt got %0d exp 0", bus.stall_cnt); else pass_cnt++;
    tick();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      if (bus.div_done === 1'b1) dones++;
      tick();
    end
    total_cnt++; if (dones !== 0) $display("FAIL mr_no_done got %0d exp 0", dones); else pass_cnt++;
    // clean DIVU; div_ready outside BUSY must be ignored
    drive(1'b0, OP_DIVU, 1'b1);
    total_cnt++; if (bus.stall !== 4'b1111) $display("FAIL mr_c0_stall got %b exp 1111", bus.stall); else pass_cnt++;
    tick();
    drive(1'b0, OP_DIVU, 1'b1);
    total_cnt++; if (bus.div_start !== 1'b1 || bus.div_signed !== 1'b0)
      $display("FAIL mr_c1 got start=%b sgn=%b exp 1/0", bus.div_start, bus.div_signed);
    else pass_cnt++;
    tick();
    drive(1'b0, OP_DIVU, 1'b1);
    total_cnt++; if (bus.state !== ST_BUSY || bus.div_done !== 1'b0)
      $display("FAIL mr_c2 got state=%0d done=%b exp 2/0", bus.state, bus.div_done);
    else pass_cnt++;
    tick();
    drive(1'b0, 8'h00, 1'b0);
    total_cnt++; if (bus.div_done !== 1'b1) $display("FAIL mr_c3_done got %b exp 1", bus.div_done); else pass_cnt++;
    tick();
    total_cnt++; if (bus.stall_cnt !== 32'd3) $display("FAIL mr_cnt2 got %0d exp 3", bus.stall_cnt); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b0, OP_DIV, 1'b0);
    tick();
    tick();
    drive(1'b0, OP_DIV, 1'b1);
    tick();
    // DONE with the old DIV still in EXE: no stall, no re-detect
    drive(1'b0, OP_DIV, 1'b0);
    total_cnt++; if (bus.div_done !== 1'b1 || bus.stall !== 4'b0000)
      $display("FAIL b2b_done got done=%b stall=%b exp 1/0000", bus.div_done, bus.stall);
    else pass_cnt++;
    tick();
    drive(1'b0, OP_DIVU, 1'b0);
    total_cnt++; if (bus.state !== ST_IDLE || bus.stall !== 4'b1111)
      $display("FAIL b2b_idle got state=%0d stall=%b exp 0/1111", bus.state, bus.stall);
    else pass_cnt++;
    tick();
    total_cnt++; if (bus.div_start !== 1'b1 || bus.div_signed !== 1'b0)
      $display("FAIL b2b_start got start=%b sgn=%b exp 1/0", bus.div_start, bus.div_signed);
    else pass_cnt++;
    tick();
    drive(1'b0, OP_DIVU, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    total_cnt++; if (bus.div_done !== 1'b1) $display("FAIL b2b_done2 got %b exp 1", bus.div_done); else pass_cnt++;
    tick();
    total_cnt++; if (bus.stall_cnt !== 32'd6) $display("FAIL b2b_cnt got %0d exp 6", bus.stall_cnt); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    test_reset();
    test_load_use();
    test_div();
    test_timeout();
    test_overlap();
    test_reset_mid_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
